// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared frame constants and receiver state encoding for the
//                serial transmitter/receiver pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam int   FRAME_DATA_BITS    = 8;
    localparam logic LINE_IDLE          = 1'b1;
    localparam int   DEFAULT_BIT_CYCLES = 106;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_bit_timer
//  Description : Bit-period counter with half/full strobes and line sampler.
//                SERIAL_RX_MAJORITY_EN selects a 2-of-3 majority sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int CNT_W      = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic i_hold,
    input  logic i_restart,
    input  logic i_s,
    output logic o_half,
    output logic o_full,
    output logic o_sample
);

`ifdef SERIAL_RX_MAJORITY_EN
    localparam int c_LATE = 1;
`else
    localparam int c_LATE = 0;
`endif

    // Decisions land c_LATE cycles after the nominal target; reloading with
    // c_LATE keeps the bit period at exactly BIT_CYCLES.
    localparam logic [CNT_W-1:0] c_HALF   = CNT_W'(BIT_CYCLES / 2 + c_LATE);
    localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(BIT_CYCLES - 1 + c_LATE);
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(c_LATE);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_hold) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= c_RELOAD;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_half = (r_cnt == c_HALF);
    assign o_full = (r_cnt == c_FULL);

`ifdef SERIAL_RX_MAJORITY_EN
    logic r_s_d1;
    logic r_s_d2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s_d1 <= LINE_IDLE;
            r_s_d2 <= LINE_IDLE;
        end else begin
            r_s_d1 <= i_s;
            r_s_d2 <= r_s_d1;
        end
    end

    assign o_sample = maj3(r_s_d2, r_s_d1, i_s);
`else
    assign o_sample = i_s;
`endif

endmodule
`default_nettype wire

// File: rtl/serial_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_frame
//  Description : Start/8-data/stop serial frame receiver with valid/ack
//                handshake and sticky error flag. Optional macro:
//                SERIAL_RX_MAJORITY_EN (2-of-3 mid-bit sampling).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_frame
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int CNT_W      = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       serial_in,
    output logic [FRAME_DATA_BITS-1:0] rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ack,
    output logic                       rx_error,
    output logic                       rx_busy
);

    localparam logic [2:0] c_LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    logic                       r_sync1;
    logic                       r_sync2;
    logic                       r_s_prev;
    logic [2:0]                 r_state;
    logic [2:0]                 w_state_nxt;
    logic [2:0]                 r_bit_idx;
    logic [FRAME_DATA_BITS-1:0] r_shift;
    logic [FRAME_DATA_BITS-1:0] r_rx_data;
    logic                       r_rx_valid;
    logic                       r_rx_error;

    logic w_fall;
    logic w_hold;
    logic w_restart;
    logic w_half;
    logic w_full;
    logic w_sample;
    logic w_stop_good;
    logic w_stop_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= LINE_IDLE;
            r_sync2  <= LINE_IDLE;
            r_s_prev <= LINE_IDLE;
        end else begin
            r_sync1  <= serial_in;
            r_sync2  <= r_sync1;
            r_s_prev <= r_sync2;
        end
    end

    assign w_fall = (r_state == IDLE) && r_s_prev && !r_sync2;

    // The counter already advances in the edge-detect cycle, so the start
    // decision lands BIT_CYCLES/2 cycles after the edge reaches the FSM.
    assign w_hold    = ((r_state == IDLE) && !w_fall) || (r_state == BREAK);
    assign w_restart = ((r_state == START) && w_half && !w_sample) ||
                       ((r_state == DATA) && w_full);

    rx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .clock     (clock),
        .reset     (reset),
        .i_hold    (w_hold),
        .i_restart (w_restart),
        .i_s       (r_sync2),
        .o_half    (w_half),
        .o_full    (w_full),
        .o_sample  (w_sample)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_nxt = START;
            START:   if (w_half) w_state_nxt = w_sample ? IDLE : DATA;
            DATA:    if (w_full && (r_bit_idx == c_LAST_BIT)) w_state_nxt = STOP;
            STOP:    if (w_full) w_state_nxt = w_sample ? IDLE : BREAK;
            BREAK:   if (r_sync2) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_stop_good = (r_state == STOP) && w_full && w_sample;
    assign w_stop_bad  = (r_state == STOP) && w_full && !w_sample;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == START) && w_half) begin
                r_bit_idx <= '0;
            end
            if ((r_state == DATA) && w_full) begin
                r_shift   <= {r_shift[FRAME_DATA_BITS-2:0], w_sample};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // A good frame always delivers; it flags overrun only if the previous
    // byte is still unconsumed and not being acknowledged this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
        end else if (w_stop_good) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            r_rx_error <= r_rx_valid && !rx_ack;
        end else begin
            if (r_rx_valid && rx_ack) begin
                r_rx_valid <= 1'b0;
            end
            if (w_stop_bad) begin
                r_rx_error <= 1'b1;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_error = r_rx_error;
    assign rx_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_rx_frame
//  Description : Directed and randomized frame bench for serial_rx_frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx_frame;

    localparam int BIT = 106;
`ifdef SERIAL_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Cycle (relative to the first low cycle of serial_in) of the stop decision
    localparam int STOP_IDX = 2 + BIT / 2 + 9 * BIT + MAJ;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    logic v_prev = 1'b0;

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;

    serial_rx_frame #(
        .BIT_CYCLES (BIT),
        .CNT_W      (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_error  (rx_error),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid && !v_prev) rises++;
        v_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"},  32'(rx_data),  32'(m_data));
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_err"},   32'(rx_error), 32'(m_err));
    endtask

    // Reference behaviour of one complete frame at its stop decision
    task automatic model_frame(input logic [7:0] d, input logic stopb, input bit ack);
        if (stopb) begin
            m_err   = m_valid && !ack;
            m_data  = d;
            m_valid = 1'b1;
        end else begin
            m_err = 1'b1;
            if (ack) m_valid = 1'b0;
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack  = 1'b0;
        m_valid = 1'b0;
        @(negedge clock);
        check("ack_clears_valid", 32'(rx_valid), 32'(0));
    endtask

    // Drives one 10-bit frame starting at the current negedge (idx 0).
    task automatic send(input logic [7:0] d, input logic stopb, input bit ack_stop,
                        input bit glitch, input int rst_at,
                        output logic v_pre, output logic v_post);
        logic [9:0] bits;
        int         idx;
        bits   = {1'b0, d, stopb};
        v_pre  = 1'bx;
        v_post = 1'bx;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < BIT; c++) begin
                idx = k * BIT + c;
                if (idx == STOP_IDX)     v_pre  = rx_valid;
                if (idx == STOP_IDX + 1) v_post = rx_valid;
                if (idx == rst_at) begin
                    reset = 1'b1;
                    #1;
                    check("rst_busy",  32'(rx_busy),  32'(0));
                    check("rst_valid", 32'(rx_valid), 32'(0));
                    check("rst_data",  32'(rx_data),  32'(0));
                    check("rst_err",   32'(rx_error), 32'(0));
                    @(negedge clock);
                    serial_in = 1'b1;
                    rx_ack    = 1'b0;
                    reset     = 1'b0;
                    return;
                end
                serial_in = (glitch && k >= 1 && k <= 8 && c == BIT / 2) ? 1'b0 : bits[9-k];
                rx_ack    = ack_stop && (idx == STOP_IDX);
                @(negedge clock);
            end
        end
        serial_in = 1'b1;
        rx_ack    = 1'b0;
    endtask

    initial begin
        logic       vp, vq;
        logic [7:0] rd;
        logic       rs;
        bit         ra;
        int         r0;

        // Reset values
        idle(3);
        check("reset_data",  32'(rx_data),  32'(0));
        check("reset_valid", 32'(rx_valid), 32'(0));
        check("reset_err",   32'(rx_error), 32'(0));
        check("reset_busy",  32'(rx_busy),  32'(0));
        reset = 1'b0;
        idle(5);

        // Good frame with exact latency
        send(8'hA5, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("lat_valid_at_stop", 32'(vp), 32'(0));
        check("lat_valid_after",   32'(vq), 32'(1));
        check_model("good_A5");
        do_ack();

        // Glitch start rejected
        r0 = rises;
        for (int i = 0; i < 80; i++) begin
            serial_in = (i < 10) ? 1'b0 : 1'b1;
            if (i == 30) check("glitch_busy_mid", 32'(rx_busy), 32'(1));
            if (i == 60) check("glitch_busy_end", 32'(rx_busy), 32'(0));
            @(negedge clock);
        end
        check("glitch_no_valid", 32'(rises - r0), 32'(0));
        check("glitch_err",      32'(rx_error),   32'(0));

        // Framing error, held-low break, then recovery
        r0 = rises;
        send(8'h3C, 1'b0, 1'b0, 1'b0, -1, vp, vq);
        serial_in = 1'b0;
        idle(300);
        serial_in = 1'b1;
        idle(20);
        model_frame(8'h3C, 1'b0, 1'b0);
        check("frm_no_valid", 32'(rises - r0), 32'(0));
        check_model("frm_3C");
        send(8'h81, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'h81, 1'b1, 1'b0);
        check_model("frm_81");
        do_ack();

        // Overrun, back-to-back frames
        send(8'h11, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'h22, 1'b1, 1'b0);
        check_model("ovr_22");

        // Reset during data bit 4, then a clean frame
        send(8'h5A, 1'b1, 1'b0, 1'b0, 5 * BIT + 10, vp, vq);
        m_data = 8'h00; m_valid = 1'b0; m_err = 1'b0;
        idle(20);
        check("post_rst_busy", 32'(rx_busy), 32'(0));
        send(8'h5A, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'h5A, 1'b1, 1'b0);
        check_model("rst_5A");
        do_ack();

        // Ack coincident with the overrunning stop sample
        send(8'h11, 1'b1, 1'b0, 1'b0, -1, vp, vq);
        model_frame(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b1, 1'b0, -1, vp, vq);
        model_frame(8'h22, 1'b1, 1'b1);
        check_model("simack_22");

        // Randomized frames
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            rd = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            ra = ($urandom_range(0, 1) == 1);
            send(rd, rs, ra, 1'b0, -1, vp, vq);
            model_frame(rd, rs, ra);
            idle(5 + $urandom_range(0, 20));
            check_model("rand");
        end

        // Mid-bit single-cycle glitches on an all-ones byte
        do_ack();
        send(8'hFF, 1'b1, 1'b0, 1'b1, -1, vp, vq);
        model_frame((MAJ == 1) ? 8'hFF : 8'h00, 1'b1, 1'b0);
        check_model("maj_FF");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_rx_frame.md
# serial_rx_frame

Serial frame receiver that sits directly downstream of the b13 sequencer/transmitter and consumes its `data_out` line.
- Recovers each frame (start bit 0, eight data bits MSB first, stop bit 1) into a parallel byte.
- Holds the byte under a valid/ack handshake.
- Flags framing and overrun errors.
- Bit timing is a counted cycle period, identical to the transmitter's pacing, so both ends share one clock domain and one parameter set.

## Interface
- `BIT_CYCLES`, default 106: clock cycles per serial bit. The transmitter emits one bit per `DelayTime+2` cycles.
- `CNT_W`, default 10: width of the bit-timing counter. Must satisfy `2^CNT_W > BIT_CYCLES`.
- `clock`, in, 1: sole clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `serial_in`, in, 1: serial line; idles high.
- `rx_data`, out, 8: last received byte; reset 0.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte; reset 0.
- `rx_ack`, in, 1: consumer takes the byte; meaningful only while `rx_valid` is 1.
- `rx_error`, out, 1: sticky framing/overrun flag; reset 0.
- `rx_busy`, out, 1: a frame is in progress (state other than IDLE); reset 0.

## Operation
- `serial_in` passes a 2-flop synchronizer whose flops reset to 1. All logic uses the synchronized value `s`.
- **IDLE**
  - Falling edge of `s` (previous 1, current 0): clear the counter, go to START.
- **START**
  - Counter counts up each cycle.
  - When it reaches `BIT_CYCLES/2` (integer division), sample `s`:
    - 0: clear the counter, bit index = 0, go to DATA.
    - 1: false start; go to IDLE with no flag.
- **DATA**
  - Each time the counter reaches `BIT_CYCLES-1`, clear it, then sample and shift into an 8-bit shift register: `sh = {sh[6:0], sample}`. The first data bit ends up as bit 7 (MSB).
  - After the 8th sample, go to STOP.
- **STOP**
  - At count `BIT_CYCLES-1`, sample:
    - 1 (good frame): `rx_data <= sh`, `rx_valid <= 1`, go to IDLE.
    - 0 (framing error): `rx_error <= 1`, `rx_data` unchanged, go to BREAK.
- **BREAK**
  - Wait for `s == 1`, then go to IDLE.
  - A held-low line therefore yields exactly one error and no spurious frames.
- **Handshake**
  - `rx_ack` while `rx_valid` is 1 clears `rx_valid` next cycle.
  - `rx_ack` while `rx_valid` is 0 is ignored.
- **Overrun**: a good stop sample while `rx_valid` is 1 and `rx_ack` is 0:
  - `rx_data` is overwritten with the new byte.
  - `rx_valid` stays 1.
  - `rx_error <= 1`.
- **Simultaneous `rx_ack` and good stop**: the new byte loads, `rx_valid` stays 1, no error.
- **`rx_error` clearing**: cleared only by a good frame delivered without overrun, or by reset.
- **Counter width**: `CNT_W` bits; it never wraps because it is cleared at `BIT_CYCLES-1`.

## Timing
- `serial_in` to `s`: 2 cycles.
- `rx_valid` rises 1 cycle after the stop-bit sample edge.
- For a start edge entering the synchronizer at cycle T0:
  - the stop sample occurs at T0 + 2 + `BIT_CYCLES/2` + 9·`BIT_CYCLES`;
  - `rx_valid` is high on the following cycle.
- Back-to-back frames with no idle gap are accepted: STOP returns to IDLE in time to see the next falling edge.
- Reset mid-frame:
  - all outputs return to reset values asynchronously;
  - the partial frame is discarded;
  - the synchronizer reloads 1, so no false start edge is generated on release.

## Configuration
- `SERIAL_RX_MAJORITY_EN` defined: each sample is the 2-of-3 majority of `s` at counts `target-1`, `target` and `target+1`.
  - The state decision moves one cycle later, at `target+1`.
  - A single-cycle glitch at mid-bit is rejected.
- `SERIAL_RX_MAJORITY_EN` not defined: a single sample at `target`; decisions at `target`.
- `rx_valid` latency relative to the stop decision is unchanged in both builds.

## Structure
- Shared package `serial_pkg`:
  - state encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3, BREAK=3'd4;
  - frame constants: `FRAME_DATA_BITS`=8, `LINE_IDLE`=1'b1;
  - default `BIT_CYCLES`=106, so transmitter and receiver agree.
- One sub-module, `rx_bit_timer`: counter with clear, `half`/`full` terminal-count strobes, and the optional majority sampler. The FSM, shift register and handshake stay in `serial_rx_frame`.

## Test plan
- **Good frame**: drive 0xA5 framed at 106 cycles/bit -> `rx_data`=0xA5 and `rx_valid`=1 at T0+2+53+954+1; `rx_error`=0.
- **Glitch start**: `serial_in` low for 10 cycles in idle -> no `rx_valid`; `rx_busy` returns to 0 at START sample; `rx_error`=0.
- **Framing error**: 0x3C with stop bit 0, line held low 300 cycles, then 0x81 good -> `rx_error`=1, no `rx_valid` for 0x3C; then `rx_data`=0x81, `rx_valid`=1, `rx_error`=0.
- **Overrun and simultaneous ack**:
  - 0x11 then 0x22 with no ack -> `rx_data`=0x22, `rx_error`=1.
  - Repeat with `rx_ack` on the 0x22 stop-sample cycle -> `rx_valid` stays 1, `rx_error`=0.
- **Reset mid-frame**: assert `reset` during DATA bit 4 -> `rx_busy`/`rx_valid`/`rx_data`/`rx_error` = 0 immediately; next 0x5A frame received correctly.
- **Majority** (`SERIAL_RX_MAJORITY_EN` on): 0xFF with a 1-cycle low pulse at each mid-bit -> `rx_data`=0xFF. With the macro off, the same stimulus -> `rx_data`=0x00.
